// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem reads under a credit cap, buffers words for decode.
// Optional macro FETCH_ILLEGAL_CHECK_EN adds a per-entry unsupported-opcode flag on dec_illegal.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [5:0]  dec_opcode,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc_plus4,
  output logic        dec_illegal
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]   instr_q [FIFO_DEPTH];
  logic [31:0]   instr_d [FIFO_DEPTH];
  logic [31:0]   pc_q    [FIFO_DEPTH];
  logic [31:0]   pc_d    [FIFO_DEPTH];
  logic [CW:0]   inflight;
  logic          req_hs, push, pop;
  logic [31:0]   redir_pc;

  // Credit covers buffered plus in-flight words, so a returning word always has a slot.
  assign inflight       = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid = (inflight < (CW+1)'(FIFO_DEPTH)) && !redirect_valid && rst_n;
  assign imem_addr      = fetch_pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign dec_valid      = (cnt_q != '0);
  assign pop            = dec_valid && dec_ready && !redirect_valid;
  assign push           = imem_rsp_valid && (disc_q == '0) && !redirect_valid;
  assign redir_pc       = redirect_pc & ~32'h3;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    disc_d     = disc_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    out_d      = out_q + CW'(req_hs) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      cnt_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      disc_d     = out_d;
    end else begin
      if (req_hs) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rsp_valid) begin
        if (disc_q != '0) disc_d   = disc_q - CW'(1);
        else              rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (push) begin
        instr_d[wptr_q] = imem_rsp_data;
        pc_d[wptr_q]    = rsp_pc_q;
        wptr_d          = wptr_q + PW'(1);
      end
      if (pop) rptr_d = rptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Storage needs no reset: outputs are gated by dec_valid.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end

  assign dec_instr    = dec_valid ? instr_q[rptr_q] : 32'h0;
  assign dec_opcode   = dec_instr[31:26];
  assign dec_pc       = dec_valid ? pc_q[rptr_q] : 32'h0;
  assign dec_pc_plus4 = dec_valid ? pc_q[rptr_q] + 32'd4 : 32'h0;

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic ill_q [FIFO_DEPTH];
  logic ill_d [FIFO_DEPTH];
  logic rsp_ill;

  always_comb begin
    case (imem_rsp_data[31:26])
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000: rsp_ill = 1'b0;
      default:                                                rsp_ill = 1'b1;
    endcase
    ill_d = ill_q;
    if (push) ill_d[wptr_q] = rsp_ill;
  end

  always_ff @(posedge clk) ill_q <= ill_d;

  assign dec_illegal = dec_valid && ill_q[rptr_q];
`else
  assign dec_illegal = 1'b0;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (cnt_q == CW'(FIFO_DEPTH))));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, streaming, stall, redirect/discard, wrap, illegal flag.
`timescale 1ns/100ps
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data, redirect_pc;
  logic        redirect_valid, dec_valid, dec_ready, dec_illegal;
  logic [31:0] dec_instr, dec_pc, dec_pc_plus4;
  logic [5:0]  dec_opcode;

`ifdef FETCH_ILLEGAL_CHECK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_opcode(dec_opcode), .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4),
    .dec_illegal(dec_illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, lat = 1, run = 0;
  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8C08_0004;
      32'h0000_0080: return 32'h0800_0010;
      32'h0000_0084: return 32'h2008_0005;
      default:       return {6'b101011, 10'h0, a[15:0]};
    endcase
  endfunction

  // Memory model: samples the handshake just before each rising edge, answers lat edges later.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk); #3;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (!rst_n) q.delete();
      else begin
        if (q.size() > 0 && q[0].due == run) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = q[0].data;
          void'(q.pop_front());
        end
        if (imem_req_valid && imem_req_ready) q.push_back('{run + lat, mem_word(imem_addr)});
      end
      run++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  // Waits (bounded) for the next decode word and checks it against the address it came from.
  task automatic expect_dec(input logic [31:0] pc, input logic ill);
    logic [31:0] w;
    logic        seen;
    w = mem_word(pc);
    seen = 1'b0;
    dec_ready = 1'b1;
    for (int n = 0; n < 30 && !seen; n++) begin
      if (dec_valid) begin
        seen = 1'b1;
        chk($sformatf("dec_pc@%h", pc), dec_pc, pc);
        chk($sformatf("dec_instr@%h", pc), dec_instr, w);
        chk($sformatf("dec_opcode@%h", pc), {26'h0, dec_opcode}, {26'h0, w[31:26]});
        chk($sformatf("dec_pc_plus4@%h", pc), dec_pc_plus4, pc + 32'd4);
        chk($sformatf("dec_illegal@%h", pc), {31'h0, dec_illegal}, {31'h0, ill});
      end
      cyc();
    end
    chk($sformatf("dec_arrived@%h", pc), {31'h0, seen}, 32'h1);
  endtask

  task automatic drain();
    imem_req_ready = 1'b0;
    dec_ready = 1'b1;
    repeat (10) cyc();
  endtask

  task automatic fill2();
    imem_req_ready = 1'b1;
    cyc();
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Reset and first fetch
    cyc();
    chk("rst_dec_valid0", {31'h0, dec_valid}, 32'h0);
    chk("rst_req_valid0", {31'h0, imem_req_valid}, 32'h0);
    cyc();
    chk("rst_dec_valid1", {31'h0, dec_valid}, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_instr", dec_instr, 32'h0);
    chk("rst_dec_illegal", {31'h0, dec_illegal}, 32'h0);
    rst_n = 1'b1; dec_ready = 1'b1;
    #1;
    chk("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_addr, 32'h0);
    cyc();
    chk("lat_not_yet", {31'h0, dec_valid}, 32'h0);
    chk("addr_after_hs", imem_addr, 32'h4);
    cyc();
    chk("first_dec_valid", {31'h0, dec_valid}, 32'h1);
    chk("first_dec_instr", dec_instr, 32'h8C08_0004);
    chk("first_dec_opcode", {26'h0, dec_opcode}, 32'h23);
    chk("first_dec_pc", dec_pc, 32'h0);
    chk("first_dec_pc4", dec_pc_plus4, 32'h4);
    cyc();
    expect_dec(32'h4, 1'b0);
    expect_dec(32'h8, 1'b0);
    expect_dec(32'hC, 1'b0);

    // Stall: FIFO fills, issue stops, nothing lost on resume
    dec_ready = 1'b0;
    repeat (10) cyc();
    chk("stall_dec_valid", {31'h0, dec_valid}, 32'h1);
    chk("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("stall_head_pc", dec_pc, 32'h10);
    chk("stall_fetch_pc", imem_addr, 32'h18);
    expect_dec(32'h10, 1'b0);
    expect_dec(32'h14, 1'b0);
    expect_dec(32'h18, 1'b0);

    // Redirect with two latency-3 fetches in flight
    drain();
    lat = 3;
    fill2();
    chk("two_outstanding", {31'h0, imem_req_valid}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("redir_no_req", {31'h0, imem_req_valid}, 32'h0);
    cyc();
    redirect_valid = 1'b0;
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_flush", {31'h0, dec_valid}, 32'h0);
    cyc();
    chk("stale1_dropped", {31'h0, dec_valid}, 32'h0);
    cyc();
    chk("stale2_dropped", {31'h0, dec_valid}, 32'h0);
    expect_dec(32'h40, 1'b0);
    expect_dec(32'h44, 1'b0);

    // Back-to-back redirects; last wins, unaligned target, response in redirect cycle
    drain();
    fill2();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    cyc();
    redirect_pc = 32'h43;
    cyc();
    redirect_valid = 1'b0;
    chk("redir43_addr", imem_addr, 32'h40);
    expect_dec(32'h40, 1'b0);
    expect_dec(32'h44, 1'b0);

    // PC wrap
    drain();
    lat = 1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req_valid", {31'h0, imem_req_valid}, 32'h1);
    cyc();
    chk("wrap_next_addr", imem_addr, 32'h0);
    expect_dec(32'hFFFF_FFFC, 1'b0);

    // Illegal-opcode flag
    drain();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    cyc();
    redirect_valid = 1'b0;
    expect_dec(32'h80, ILL_EN);
    expect_dec(32'h84, 1'b0);
    expect_dec(32'h88, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
